// File: rtl/md_sched.sv
// Multiply/divide sequencer with HI/LO commit: fixed-latency busy counter,
// pending-result holding registers and the D-stage stall request.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  input  logic        rd_hi,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;

  logic        busy_s, op_valid_s, op_long_s, start_eff_s;
  logic [63:0] prod_s, produ_s;
  logic [31:0] div_b_s, quot_s, rem_s, quotu_s, remu_s;

  assign busy_s      = (state_q == ST_RUN);
  assign op_valid_s  = (md_op >= OP_MULT) && (md_op <= OP_MTLO);
  assign op_long_s   = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign start_eff_s = start & ~busy_s & op_valid_s;

  // Arithmetic datapath; a zero divisor is swapped for 1 so the divider never sees it.
  always_comb begin
    div_b_s = (b == 32'd0) ? 32'd1 : b;
    prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    produ_s = {32'd0, a} * {32'd0, b};
    quot_s  = $signed(a) / $signed(div_b_s);
    rem_s   = $signed(a) % $signed(div_b_s);
    quotu_s = a / div_b_s;
    remu_s  = a % div_b_s;
  end

  // State register and architectural/pending registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
    end
  end

  // Next-state logic for the IDLE/RUN sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_eff_s && op_long_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter, pending-result capture and HI/LO update.
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    p_hi_d = p_hi_q;
    p_lo_d = p_lo_q;
    if (busy_s) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = p_hi_q;
        lo_d = p_lo_q;
      end else begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end else if (start_eff_s) begin
      case (md_op)
        OP_MULT: begin
          {p_hi_d, p_lo_d} = prod_s;
          cnt_d = 4'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {p_hi_d, p_lo_d} = produ_s;
          cnt_d = 4'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          // Divide by zero leaves HI/LO as they are once the op commits.
          if (b == 32'd0) begin
            p_hi_d = hi_q;
            p_lo_d = lo_q;
          end else if (md_op == OP_DIV) begin
            p_hi_d = rem_s;
            p_lo_d = quot_s;
          end else begin
            p_hi_d = remu_s;
            p_lo_d = quotu_s;
          end
          cnt_d = 4'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        default: cnt_d = cnt_q;
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Outputs: busy, stall request and read mux.
  always_comb begin
    busy     = busy_s;
    stall_md = d_is_md & (start_eff_s | busy_s);
    hi       = hi_q;
    lo       = lo_q;
    md_rdata = rd_hi ? hi_q : lo_q;
  end

endmodule
